// File: rtl/tile_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_writeback_ctrl                                                        |
// | Drains an accumulator tile to memory in MEM_BW-lane requantised beats.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tile_writeback_ctrl #(
  parameter int TILE_ROWS  = 4,
  parameter int TILE_COLS  = 64,
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_BW     = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [$clog2(TILE_ROWS+1)-1:0]   cfg_rows_i,
  input  logic [$clog2(TILE_COLS+1)-1:0]   cfg_cols_i,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr_i,
  input  logic [ADDR_WIDTH-1:0]            cfg_row_stride_i,
  input  logic [SHIFT_W-1:0]               cfg_shift_i,
  input  logic                             cfg_sat_en_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             rd_en_o,
  output logic [$clog2(TILE_ROWS)-1:0]     rd_row_o,
  output logic [$clog2(TILE_COLS)-1:0]     rd_col_o,
  input  logic [MEM_BW*ACC_WIDTH-1:0]      rd_data_i,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [MEM_BW*DATA_WIDTH-1:0]     mem_data_o,
  output logic [MEM_BW-1:0]                mem_mask_o,
  output logic                             mem_last_o
);

  localparam int c_rw  = $clog2(TILE_ROWS+1);
  localparam int c_cw  = $clog2(TILE_COLS+1);
  localparam int c_rrw = $clog2(TILE_ROWS);
  localparam int c_rcw = $clog2(TILE_COLS);

  localparam logic signed [ACC_WIDTH:0] c_one     = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] c_sat_max =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] c_sat_min = ~c_sat_max;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CONV = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                       state_q;
  logic [c_rw-1:0]              rows_q;
  logic [c_cw-1:0]              cols_q;
  logic [ADDR_WIDTH-1:0]        stride_q;
  logic [ADDR_WIDTH-1:0]        row_base_q;
  logic [SHIFT_W-1:0]           shift_q;
  logic                         sat_q;
  logic [c_rrw-1:0]             row_q;
  logic [c_rcw-1:0]             col_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         rd_en_q;
  logic                         mem_valid_q;
  logic [ADDR_WIDTH-1:0]        mem_addr_q;
  logic [MEM_BW*DATA_WIDTH-1:0] mem_data_q;
  logic [MEM_BW-1:0]            mem_mask_q;
  logic                         mem_last_q;

  logic [c_rw-1:0]              w_rows_clamp;
  logic [c_cw-1:0]              w_cols_clamp;
  logic [c_cw:0]                w_col_end;
  logic                         w_row_end;
  logic                         w_last;
  logic [MEM_BW-1:0]            w_mask;
  logic [MEM_BW*DATA_WIDTH-1:0] w_conv;

  // Round-half-up arithmetic shift; one guard bit keeps the rounding add from overflowing.
  function automatic logic [DATA_WIDTH-1:0] f_requant(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [SHIFT_W-1:0]   sh,
    input logic                 sat
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] v;
    logic [DATA_WIDTH-1:0]     res;
    ext = $signed({acc[ACC_WIDTH-1], acc});
    if (sh == '0) begin
      v = ext;
    end else begin
      v = (ext + (c_one << (sh - SHIFT_W'(1)))) >>> sh;
    end
    res = v[DATA_WIDTH-1:0];
    if (sat) begin
      if (v > c_sat_max) begin
        res = c_sat_max[DATA_WIDTH-1:0];
      end else if (v < c_sat_min) begin
        res = c_sat_min[DATA_WIDTH-1:0];
      end
    end
    return res;
  endfunction

  assign w_rows_clamp = (cfg_rows_i > c_rw'(TILE_ROWS)) ? c_rw'(TILE_ROWS) : cfg_rows_i;
  assign w_cols_clamp = (cfg_cols_i > c_cw'(TILE_COLS)) ? c_cw'(TILE_COLS) : cfg_cols_i;

  assign w_col_end = (c_cw+1)'(col_q) + (c_cw+1)'(MEM_BW);
  assign w_row_end = (w_col_end >= {1'b0, cols_q});
  assign w_last    = w_row_end && (c_rw'(row_q) == (rows_q - c_rw'(1)));

  generate
    for (genvar k = 0; k < MEM_BW; k++) begin : g_lane
      logic [c_cw:0] w_idx;
      assign w_idx     = (c_cw+1)'(col_q) + (c_cw+1)'(k);
      assign w_mask[k] = (w_idx < {1'b0, cols_q});
      assign w_conv[k*DATA_WIDTH +: DATA_WIDTH] =
        w_mask[k] ? f_requant(rd_data_i[k*ACC_WIDTH +: ACC_WIDTH], shift_q, sat_q) : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      shift_q     <= '0;
      sat_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
      mem_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rows_q     <= w_rows_clamp;
            cols_q     <= w_cols_clamp;
            stride_q   <= cfg_row_stride_i;
            row_base_q <= cfg_base_addr_i;
            shift_q    <= cfg_shift_i;
            sat_q      <= cfg_sat_en_i;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
            if ((w_rows_clamp == '0) || (w_cols_clamp == '0)) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_CONV;
        end
        S_CONV: begin
          mem_valid_q <= 1'b1;
          mem_addr_q  <= row_base_q + ADDR_WIDTH'(col_q);
          mem_data_q  <= w_conv;
          mem_mask_q  <= w_mask;
          mem_last_q  <= w_last;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            if (mem_last_q) begin
              state_q <= S_DONE;
            end else begin
              // Row base tracks base + row*stride incrementally.
              if (w_row_end) begin
                col_q      <= '0;
                row_q      <= row_q + c_rrw'(1);
                row_base_q <= row_base_q + stride_q;
              end else begin
                col_q <= col_q + c_rcw'(MEM_BW);
              end
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_row_o    = row_q;
  assign rd_col_o    = col_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_mask_o  = mem_mask_q;
  assign mem_last_o  = mem_last_q;

endmodule
`default_nettype wire
